// File: rtl/fetch_queue.sv
// Instruction fetch queue: 32-byte circular buffer of line fills presenting a 16-byte window at EIP.
// Optional macro FETCHQ_STATS_EN adds the stall_cycles counter output.
module fetch_queue #(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000,
  parameter logic [15:0] RESET_CS  = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  output logic [31:0]  fetch_addr,
  output logic         fill_ready,
  input  logic         fill_valid,
  input  logic [127:0] fill_data,
  input  logic         flush,
  input  logic [31:0]  flush_eip,
  input  logic [15:0]  flush_cs,
  output logic         ir_valid,
  output logic [127:0] IR,
  output logic [31:0]  EIP,
  output logic [15:0]  CS,
  input  logic         dec_ready,
  input  logic [3:0]   instr_length_updt
`ifdef FETCHQ_STATS_EN
  ,
  output logic [15:0]  stall_cycles
`endif
);

  logic [7:0] buf_q [0:31];
  logic       wr_line;
  logic [4:0] rd_ptr;
  logic [5:0] count;
  logic [3:0] skip;

  logic       fill;
  logic       consume;
  logic [5:0] fill_amt;
  logic [5:0] cons_amt;
  logic [5:0] count_nxt;

  always_comb begin
    fill_ready = (count <= 6'd16) && !flush;
    ir_valid   = (count >= 6'd16);
    fill       = fill_valid && fill_ready;
    consume    = ir_valid && dec_ready && (instr_length_updt != 4'd0);
    fill_amt   = fill ? (6'd16 - {2'b00, skip}) : 6'd0;
    cons_amt   = consume ? {2'b00, instr_length_updt} : 6'd0;
    count_nxt  = count + fill_amt - cons_amt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_line    <= 1'b0;
      rd_ptr     <= {1'b0, RESET_EIP[3:0]};
      count      <= 6'd0;
      skip       <= RESET_EIP[3:0];
      EIP        <= RESET_EIP;
      CS         <= RESET_CS;
      fetch_addr <= {RESET_EIP[31:4], 4'h0};
    end else if (flush) begin
      wr_line    <= 1'b0;
      rd_ptr     <= {1'b0, flush_eip[3:0]};
      count      <= 6'd0;
      skip       <= flush_eip[3:0];
      EIP        <= flush_eip;
      CS         <= flush_cs;
      fetch_addr <= {flush_eip[31:4], 4'h0};
    end else begin
      count <= count_nxt;
      if (fill) begin
        wr_line    <= ~wr_line;
        fetch_addr <= fetch_addr + 32'd16;
        skip       <= 4'd0;
      end
      if (consume) begin
        rd_ptr <= rd_ptr + {1'b0, instr_length_updt};
        EIP    <= EIP + {28'd0, instr_length_updt};
      end
    end
  end

  // Byte storage is cleared only by reset; a flush just discards it logically via count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h00;
    end else if (fill && !flush) begin
      for (int i = 0; i < 16; i++) buf_q[{wr_line, 4'(i)}] <= fill_data[127-8*i -: 8];
    end
  end

  always_comb begin
    IR = '0;
    for (int i = 0; i < 16; i++) IR[127-8*i -: 8] = buf_q[5'(rd_ptr + 5'(i))];
  end

`ifdef FETCHQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 16'd0;
    end else if (flush) begin
      stall_cycles <= 16'd0;
    end else if (dec_ready && !ir_valid && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes expected windows, a negedge monitor checks each consume.
module tb_fetch_queue;
  logic         clk;
  logic         reset;
  logic [31:0]  fetch_addr;
  logic         fill_ready;
  logic         fill_valid;
  logic [127:0] fill_data;
  logic         flush;
  logic [31:0]  flush_eip;
  logic [15:0]  flush_cs;
  logic         ir_valid;
  logic [127:0] IR;
  logic [31:0]  EIP;
  logic [15:0]  CS;
  logic         dec_ready;
  logic [3:0]   len;
`ifdef FETCHQ_STATS_EN
  logic [15:0]  stall_cycles;
`endif

  fetch_queue #(.RESET_EIP(32'h0000_1000), .RESET_CS(16'h0000)) dut (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr), .fill_ready(fill_ready),
    .fill_valid(fill_valid), .fill_data(fill_data), .flush(flush), .flush_eip(flush_eip),
    .flush_cs(flush_cs), .ir_valid(ir_valid), .IR(IR), .EIP(EIP), .CS(CS),
    .dec_ready(dec_ready), .instr_length_updt(len)
`ifdef FETCHQ_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic [127:0] ir;
    logic [31:0]  eip;
    logic [15:0]  cs;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sixteen consecutive byte values starting at s, first byte in the top lane.
  function automatic logic [127:0] win(input logic [7:0] s);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[127-8*i -: 8] = s + 8'(i);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_consume(input logic [7:0] s, input logic [31:0] e, input logic [15:0] c);
    exp_t x;
    x.ir = win(s);
    x.eip = e;
    x.cs = c;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    if (reset && !flush && ir_valid && dec_ready && len != 4'd0) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_consume: got EIP %h expected no consume", EIP);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("mon_IR", IR, x.ir);
        chk("mon_EIP", {96'd0, EIP}, {96'd0, x.eip});
        chk("mon_CS", {112'd0, CS}, {112'd0, x.cs});
      end
    end
  end

  initial begin
    reset = 1'b0; fill_valid = 1'b0; fill_data = '0; flush = 1'b0;
    flush_eip = '0; flush_cs = '0; dec_ready = 1'b0; len = 4'd0;
    step(); step();
    chk("rst_fill_ready", {127'd0, fill_ready}, 128'd1);
    chk("rst_ir_valid", {127'd0, ir_valid}, 128'd0);
    chk("rst_fetch_addr", {96'd0, fetch_addr}, {96'd0, 32'h0000_1000});
    chk("rst_EIP", {96'd0, EIP}, {96'd0, 32'h0000_1000});
    chk("rst_CS", {112'd0, CS}, 128'd0);
    chk("rst_IR", IR, 128'd0);
    reset = 1'b1;

    // first line: one cycle to ir_valid
    fill_valid = 1'b1; fill_data = win(8'h00);
    step();
    fill_valid = 1'b0;
    chk("fill1_ir_valid", {127'd0, ir_valid}, 128'd1);
    chk("fill1_IR", IR, 128'h000102030405060708090A0B0C0D0E0F);
    chk("fill1_EIP", {96'd0, EIP}, {96'd0, 32'h0000_1000});
    chk("fill1_fetch_addr", {96'd0, fetch_addr}, {96'd0, 32'h0000_1010});

    fill_valid = 1'b1; fill_data = win(8'h10);
    step();
    fill_valid = 1'b0;
    chk("full_fill_ready", {127'd0, fill_ready}, 128'd0);

    dec_ready = 1'b1; len = 4'd3; expect_consume(8'h00, 32'h1000, 16'h0);
    step();
    dec_ready = 1'b0; len = 4'd0;
    chk("c3_EIP", {96'd0, EIP}, {96'd0, 32'h0000_1003});
    chk("c3_IR_top", {120'd0, IR[127:120]}, 128'h03);
    chk("c3_fill_ready", {127'd0, fill_ready}, 128'd0);

    dec_ready = 1'b1; len = 4'd13; expect_consume(8'h03, 32'h1003, 16'h0);
    step();
    len = 4'd14; expect_consume(8'h10, 32'h1010, 16'h0);
    chk("c13_fill_ready", {127'd0, fill_ready}, 128'd1);
    step();
    // count is now 2: decode requests must not move anything
    len = 4'd5;
    chk("low_ir_valid", {127'd0, ir_valid}, 128'd0);
    step();
    dec_ready = 1'b0; len = 4'd0;
    chk("idle_EIP", {96'd0, EIP}, {96'd0, 32'h0000_101E});

    // third line lands in buffer line 0; window wraps 30,31,0..13
    fill_valid = 1'b1; fill_data = win(8'h20);
    step();
    fill_valid = 1'b0;
    chk("wrap_ir_valid", {127'd0, ir_valid}, 128'd1);
    chk("wrap_IR", IR, 128'h1E1F202122232425262728292A2B2C2D);
    chk("wrap_fetch_addr", {96'd0, fetch_addr}, {96'd0, 32'h0000_1030});

    dec_ready = 1'b1; len = 4'd2; expect_consume(8'h1E, 32'h101E, 16'h0);
    step();
    fill_valid = 1'b1; fill_data = win(8'h30);
    len = 4'd7; expect_consume(8'h20, 32'h1020, 16'h0);
    step();
    fill_valid = 1'b0; dec_ready = 1'b0; len = 4'd0;
    chk("fc_ir_valid", {127'd0, ir_valid}, 128'd1);
    chk("fc_fill_ready", {127'd0, fill_ready}, 128'd0);
    chk("fc_EIP", {96'd0, EIP}, {96'd0, 32'h0000_1027});
    chk("fc_IR", IR, win(8'h27));

    // redirect with a colliding fill and decode request
    flush = 1'b1; flush_eip = 32'h0000_2005; flush_cs = 16'h0008;
    fill_valid = 1'b1; fill_data = {16{8'hAA}}; dec_ready = 1'b1; len = 4'd3;
    #1;
    chk("flush_fill_ready", {127'd0, fill_ready}, 128'd0);
    step();
    flush = 1'b0; fill_valid = 1'b0; dec_ready = 1'b0; len = 4'd0;
    chk("flush_fetch_addr", {96'd0, fetch_addr}, {96'd0, 32'h0000_2000});
    chk("flush_ir_valid", {127'd0, ir_valid}, 128'd0);
    chk("flush_EIP", {96'd0, EIP}, {96'd0, 32'h0000_2005});
    chk("flush_CS", {112'd0, CS}, {112'd0, 16'h0008});

    fill_valid = 1'b1; fill_data = win(8'h40);
    step();
    chk("rd1_ir_valid", {127'd0, ir_valid}, 128'd0);
    chk("rd1_fill_ready", {127'd0, fill_ready}, 128'd1);
    fill_data = win(8'h50);
    step();
    fill_valid = 1'b0;
    chk("rd2_ir_valid", {127'd0, ir_valid}, 128'd1);
    chk("rd2_IR_top", {120'd0, IR[127:120]}, 128'h45);
    dec_ready = 1'b1; len = 4'd4; expect_consume(8'h45, 32'h2005, 16'h0008);
    step();
    dec_ready = 1'b0; len = 4'd0;
    chk("rd2_EIP", {96'd0, EIP}, {96'd0, 32'h0000_2009});

    // asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("arst_EIP", {96'd0, EIP}, {96'd0, 32'h0000_1000});
    chk("arst_ir_valid", {127'd0, ir_valid}, 128'd0);
    chk("arst_fetch_addr", {96'd0, fetch_addr}, {96'd0, 32'h0000_1000});
    chk("arst_IR", IR, 128'd0);
    chk("arst_CS", {112'd0, CS}, 128'd0);
    step();
    reset = 1'b1;

`ifdef FETCHQ_STATS_EN
    dec_ready = 1'b1;
    repeat (5) step();
    dec_ready = 1'b0;
    chk("stall_count", {112'd0, stall_cycles}, 128'd5);
    flush = 1'b1; flush_eip = 32'h0000_1000; flush_cs = 16'h0000;
    step();
    flush = 1'b0;
    chk("stall_flush", {112'd0, stall_cycles}, 128'd0);
`endif

    step();
    chk("sb_drained", 128'(sbq.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
